// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath selects and write enables from the state register.
module main_control_fsm #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Op,
  input  logic           MemReady,
  output logic           IorD,
  output logic           ALUSrcA,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           Branch,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           IllegalOp,
  output logic [3:0]     State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Unused codes 12-15 fall through to the default and recover to FETCH.
  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:   state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = MEMADR;
        else if (Op == OP_RTYP)         state_d = EXECUTE;
        else if (Op == OP_BEQ)          state_d = BRANCH;
        else if (Op == OP_ADDI)         state_d = ADDIEX;
        else if (Op == OP_J)            state_d = JUMP;
        else                            illegal_d = 1'b1;
      end
      MEMADR: begin
        if (Op == OP_LW)      state_d = MEMRD;
        else if (Op == OP_SW) state_d = MEMWR;
      end
      MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:   state_d = MemReady ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = MemReady;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every write enable immediately, before the state register reacts.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign IllegalOp = illegal_q;
  assign State     = state_q;

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter: OPW, default 6, width of the Op field input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 Op  input  OPW  instruction opcode, Instr[31:26], valid from DECODE onward.
REQ-005 MemReady  input  1  memory access-complete handshake, relevant in FETCH, MEMRD, MEMWR only.
REQ-006 IorD, ALUSrcA, RegDst, MemtoReg  output  1 each  datapath mux selects.
REQ-007 ALUSrcB  output  2  ALU B-input select: 00 Reg2, 01 constant 4, 10 SignExt, 11 ShiftL.
REQ-008 ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded.
REQ-009 PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 IRWrite, PCWrite, Branch, RegWrite, MemWrite  output  1 each  write enables.
REQ-011 IllegalOp  output  1  registered one-cycle flag for an unsupported opcode.
REQ-012 State  output  4  current state code, for debug and verification.

Function
REQ-013 The FSM SHALL implement the states and codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014 Codes 12-15 SHALL never be held; if one is reached, the next state SHALL be FETCH.
REQ-015 Transitions SHALL be as follows:
- FETCH->DECODE when MemReady=1, otherwise stay in FETCH.
- DECODE->MEMADR for Op 100011 (lw) or 101011 (sw).
- DECODE->EXECUTE for Op 000000 (R-type).
- DECODE->BRANCH for Op 000100 (beq).
- DECODE->ADDIEX for Op 001000 (addi).
- DECODE->JUMP for Op 000010 (j).
- DECODE->FETCH for any other Op.
REQ-016 Further transitions SHALL be as follows:
- MEMADR->MEMRD for lw, MEMADR->MEMWR for sw; Op is re-sampled in MEMADR.
- MEMRD->MEMWB when MemReady=1, otherwise stay.
- MEMWR->FETCH when MemReady=1, otherwise stay.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
- EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-017 Outputs SHALL be combinational decodes of the state register; every output not listed for a state SHALL be 0.
REQ-018 Output values per state SHALL be:
- FETCH: ALUSrcB=01, IRWrite=MemReady, PCWrite=MemReady.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=MemReady.
- EXECUTE: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-019 Each write enable (IRWrite, PCWrite, RegWrite, MemWrite, Branch) SHALL assert for exactly one cycle per instruction, except when a MemReady stall is in progress.
REQ-020 IllegalOp SHALL be 1 in the cycle after DECODE takes the default (unsupported-Op) transition, and 0 otherwise.
REQ-021 Instruction latency with MemReady held at 1 SHALL be: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
REQ-022 Each cycle MemReady=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency, with all other outputs held.

Reset
REQ-023 While reset=1 at a clk edge, the next state SHALL be FETCH and IllegalOp SHALL be 0.
REQ-024 Reset SHALL take priority over every transition, including a reset asserted mid-instruction.
REQ-025 While reset=1, IRWrite, PCWrite, RegWrite, MemWrite and Branch SHALL be forced to 0, regardless of state or MemReady.
REQ-026 In the first cycle after reset is released, State SHALL be 0 and ALUSrcB SHALL be 01.

Verification
REQ-027 lw, MemReady=1: Op=100011 -> State sequence 0,1,2,3,4,0; ALUSrcB sequence 01,11,10,00,00; RegWrite=1 only in state 4.
REQ-028 sw with stall: Op=101011, MemReady=0 for the first 2 cycles in MEMWR -> State 5 held for 3 cycles; MemWrite=1 only in the third of those cycles, then State=0.
REQ-029 R-type then beq, back to back: Op=000000 -> states 0,1,6,7; then Op=000100 -> states 0,1,8; ALUOp=10 in state 6 and 01 in state 8; Branch=1 only in state 8.
REQ-030 Illegal opcode: Op=111111 in DECODE -> next State=0, IllegalOp=1 for exactly that one cycle, no write enable asserted.
REQ-031 Reset mid-instruction: assert reset while State=3 -> next State=0; during reset, PCWrite=IRWrite=0 even with MemReady=1.
REQ-032 Fetch stall: MemReady=0 for 3 cycles in FETCH -> State=0 held; IRWrite=PCWrite=0; on the MemReady=1 cycle both are 1 and the next State=1.
